syscall_sequencer: RTL and testbench
====================================

# syscall_sequencer

Controls the system-call service path of the MIPS core. When decode flags a SYSCALL, the block stalls the pipeline and waits for older instructions to drain. It then dispatches on `$v0` and runs the service: integer print, string print through a byte-wide memory read port, character print, or exit. Output goes to a byte-wide console through a valid/ready handshake, and the block releases the pipeline once the service is complete.

## Interface
- `MAX_STR_LEN`, default 256: maximum bytes emitted per string print; the string is truncated beyond this.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `syscall_req` in 1: the instruction in decode is SYSCALL (opcode 0, funct 6'h0C).
- `pipe_empty` in 1: all instructions older than the syscall have retired.
- `v0` in 32: service code, already forwarded.
- `a0` in 32: service argument, already forwarded.
- `stall` out 1: freezes PC and the IF/ID stages.
- `syscall_done` out 1: one-cycle pulse when the service completes.
- `halt` out 1: sticky; set by the exit service.
- `svc_err` out 1: one-cycle pulse when `v0` is an unknown code.
- `mem_req` out 1, `mem_addr` out 32: byte read request.
- `mem_ack` in 1, `mem_rdata` in 8: read response.
- `con_valid` out 1, `con_data` out 8: console byte.
- `con_ready` in 1: console accepts the byte.
- `stat_syscalls` out 32, `stat_chars` out 32: statistics counters.

## Operation
- Service codes:
  - 1: print `a0` as signed decimal followed by 0x0A.
  - 4: print the NUL-terminated string at address `a0`.
  - 10: exit.
  - 11: print the character `a0[7:0]`.
  - Any other code: pulse `svc_err`, then complete as DONE.
- FSM states: IDLE, DRAIN, DISPATCH, INT_SIGN, INT_DIGIT, STR_FETCH, EMIT, DONE, HALT.
- IDLE → DRAIN on `syscall_req`.
- DRAIN → DISPATCH in the first cycle `pipe_empty`=1. `v0` and `a0` are latched in that cycle.
- DISPATCH branches on the latched `v0`.
- Integer print (service 1):
  - If negative, emit '-' (0x2D) and take magnitude = −`a0` as unsigned; 0x80000000 gives 2147483648.
  - Digits are generated by repeated subtraction against a power-of-ten table, 10^9 down to 10^0, one subtraction per cycle.
  - A digit is emitted as 0x30+count when count≠0, when a digit has already been emitted, or at index 0.
  - Leading zeros are suppressed; zero prints as "0". After the last digit, emit 0x0A.
- String print (service 4):
  - STR_FETCH issues `mem_addr`=`a0`+offset and holds `mem_req` until `mem_ack`.
  - A NUL byte, or offset=`MAX_STR_LEN`, goes to DONE; otherwise the byte goes to EMIT and offset increments.
- EMIT holds `con_valid` with stable `con_data` until `con_ready`, then returns to the calling sequence.
- Exit (service 10) → HALT. HALT is terminal until `rst`: `halt`=1 and `stall`=1.
- DONE lasts one cycle: `syscall_done`=1 and `stall`=0, then IDLE. `syscall_req` is ignored in DONE.

## Timing
- `stall` = (state==IDLE && `syscall_req`) || (state ∉ {IDLE, DONE}). It is combinational, so the stall takes effect in the same cycle as detection.
- Latency for service 11 is at least 4 cycles from `syscall_req` to `syscall_done`, with `pipe_empty` and `con_ready` tied high.
- Per-digit cost is (digit value + 1) cycles, plus one EMIT cycle for each emitted digit.
- `mem_req` is never asserted in the same cycle as `con_valid`.
- `svc_err` pulses in the DISPATCH cycle.
- Reset values of outputs: `stall`, `syscall_done`, `halt`, `svc_err`, `mem_req`, `con_valid` = 0; `mem_addr`, `con_data` = 0; both statistics counters = 0.
- `rst` mid-service returns the block to IDLE next cycle. Any pending handshake is dropped, with no pulse on `syscall_done`.
- Statistics counters wrap at 2^32.

## Configuration
- `SYSCALL_STATS_EN` defined:
  - `stat_syscalls` increments on each DISPATCH.
  - `stat_chars` increments on each accepted console byte (`con_valid` && `con_ready`).
- `SYSCALL_STATS_EN` undefined: both counters are absent, and the ports are driven constant 0.

## Structure
- Package `syscall_pkg` holds:
  - the state enum;
  - service-code constants (SVC_PRINT_INT, SVC_PRINT_STR, SVC_EXIT, SVC_PRINT_CHAR);
  - ASCII constants (minus, '0', newline, NUL);
  - the 10-entry power-of-ten table.
- Sub-module `sys_int_to_ascii` is the digit generator. Interface:
  - inputs: start, magnitude;
  - outputs: digit valid/ready handshake, last.

## Test plan
- `v0`=1, `a0`=−1234, `con_ready` always 1 → bytes 2D 31 32 33 34 0A, then one `syscall_done` pulse; `stall` is high from the `syscall_req` cycle until DONE.
- `v0`=1, `a0`=0, then `a0`=0x80000000 → "0\n", then "-2147483648\n".
- `v0`=4, memory holds "Hi\0" at 0x100, `con_ready` toggling every other cycle → bytes 48 69 exactly once each, `con_data` stable while `con_valid` waits, and 3 memory reads at addresses 0x100–0x102.
- `pipe_empty` low for 5 cycles after `syscall_req`, `v0`=11, `a0`=0x41 → no console activity during drain, then byte 41; operands are latched in the `pipe_empty` cycle.
- `v0`=10 → `halt`=1 held along with `stall`; a later `syscall_req` is ignored until `rst`. `v0`=7 → `svc_err` pulse, then `syscall_done`.
- `rst` during digit 3 of a print → all outputs at reset values next cycle; a new syscall afterwards prints correctly. With `SYSCALL_STATS_EN` defined, the counters match the byte and syscall counts, and reset to 0.

Source files
------------

// File: rtl/syscall_sequencer_pkg.sv
// Shared types and constants for the syscall sequencer: FSM state encoding,
// MIPS service codes, ASCII bytes used by the print services, and the
// power-of-ten table used by the decimal digit generator.
package syscall_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned NUM_DIGITS = 10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DISPATCH,
    ST_INT_SIGN,
    ST_INT_DIGIT,
    ST_STR_FETCH,
    ST_EMIT,
    ST_DONE,
    ST_HALT
  } state_e;

  localparam logic [XLEN-1:0] SVC_PRINT_INT  = 32'd1;
  localparam logic [XLEN-1:0] SVC_PRINT_STR  = 32'd4;
  localparam logic [XLEN-1:0] SVC_EXIT       = 32'd10;
  localparam logic [XLEN-1:0] SVC_PRINT_CHAR = 32'd11;

  localparam logic [BYTE_W-1:0] ASCII_MINUS = 8'h2D;
  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_NL    = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_NUL   = 8'h00;

  // Entry i holds 10^i.
  localparam logic [NUM_DIGITS-1:0][XLEN-1:0] POW10 = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000,      32'd1000,      32'd100,      32'd10,      32'd1
  };

endpackage

// File: rtl/syscall_sequencer_if.sv
// Memory read port and console byte port of the syscall sequencer.
//   mem_req/mem_addr -> byte read request, mem_ack/mem_rdata <- response
//   con_valid/con_data -> console byte, con_ready <- console accepts
interface syscall_sequencer_if;
  import syscall_pkg::*;

  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_ack;
  logic [BYTE_W-1:0] mem_rdata;
  logic              con_valid;
  logic [BYTE_W-1:0] con_data;
  logic              con_ready;

  modport master (
    output mem_req, mem_addr, con_valid, con_data,
    input  mem_ack, mem_rdata, con_ready
  );

  modport slave (
    input  mem_req, mem_addr, con_valid, con_data,
    output mem_ack, mem_rdata, con_ready
  );

endinterface

// File: rtl/syscall_sequencer_int_to_ascii.sv
// sys_int_to_ascii: decimal digit generator for an unsigned 32-bit magnitude.
// Repeated subtraction against 10^9..10^0, one subtraction per cycle; a digit
// costs (value + 1) cycles. Leading zeros are skipped, index 0 always emits.
// Ports: clk, rst (sync, active-high), start_i/magnitude_i (load),
//        digit_valid_o/digit_ready_i (handshake), digit_o, last_o.
module sys_int_to_ascii
  import syscall_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [XLEN-1:0]    magnitude_i,
  input  logic               digit_ready_i,
  output logic               digit_valid_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               last_o
);

  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               seen_q, seen_d;
  logic               last_q, last_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGIT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    pow_c;

  assign pow_c = POW10[idx_q];

  // Subtract-or-advance step; a finished digit is held until accepted.
  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    last_d  = last_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      busy_d  = 1'b1;
      valid_d = 1'b0;
      seen_d  = 1'b0;
      last_d  = 1'b0;
      rem_d   = magnitude_i;
      idx_d   = IDX_W'(NUM_DIGITS - 1);
      cnt_d   = '0;
    end else if (valid_q) begin
      if (digit_ready_i) begin
        valid_d = 1'b0;
        seen_d  = 1'b1;
        cnt_d   = '0;
        if (idx_q == '0) busy_d = 1'b0;
        else             idx_d  = idx_q - IDX_W'(1);
      end
    end else if (busy_q) begin
      if (rem_q >= pow_c) begin
        rem_d = rem_q - pow_c;
        cnt_d = cnt_q + DIGIT_W'(1);
      end else if (cnt_q != '0 || seen_q || idx_q == '0) begin
        valid_d = 1'b1;
        last_d  = (idx_q == '0);
      end else begin
        idx_d = idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
      last_q  <= 1'b0;
      rem_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign digit_valid_o = valid_q;
  assign digit_o       = cnt_q;
  assign last_o        = last_q;

endmodule

// File: rtl/syscall_sequencer.sv
// syscall_sequencer: stalls the pipeline on SYSCALL, waits for older
// instructions to drain, then runs the service selected by $v0 (print int,
// print string, print char, exit) and releases the pipeline when done.
// Ports: clk, rst (sync, active-high), syscall_req_i, pipe_empty_i, v0_i, a0_i,
//        stall_c_o (combinational), syscall_done_o, halt_o, svc_err_o,
//        stat_syscalls_o, stat_chars_o, bus (memory + console, master side).
// Optional: define SYSCALL_STATS_EN to enable the statistics counters;
//           otherwise both stat ports read 0.
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            syscall_req_i,
  input  logic            pipe_empty_i,
  input  logic [XLEN-1:0] v0_i,
  input  logic [XLEN-1:0] a0_i,
  output logic            stall_c_o,
  output logic            syscall_done_o,
  output logic            halt_o,
  output logic            svc_err_o,
  output logic [XLEN-1:0] stat_syscalls_o,
  output logic [XLEN-1:0] stat_chars_o,
  syscall_sequencer_if.master bus
);

  state_e              state_q, state_d, ret_q, ret_d;
  logic [XLEN-1:0]     v0_q, v0_d, a0_q, a0_d, off_q, off_d;
  logic [XLEN-1:0]     maddr_q, maddr_d;
  logic [BYTE_W-1:0]   cdata_q, cdata_d;
  logic                nl_q, nl_d, done_q, done_d, halt_q, halt_d;
  logic                err_q, err_d, mreq_q, mreq_d, cvalid_q, cvalid_d;

  logic                gen_start;
  logic                dig_ready, dig_valid, dig_last;
  logic [DIGIT_W-1:0]  dig_val;
  logic [XLEN-1:0]     mag_c;

  // Two's-complement magnitude; 0x80000000 maps to 2147483648 unsigned.
  assign mag_c = a0_q[XLEN-1] ? (~a0_q + XLEN'(1)) : a0_q;

  sys_int_to_ascii u_int_to_ascii (
    .clk           (clk),
    .rst           (rst),
    .start_i       (gen_start),
    .magnitude_i   (mag_c),
    .digit_ready_i (dig_ready),
    .digit_valid_o (dig_valid),
    .digit_o       (dig_val),
    .last_o        (dig_last)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    v0_d      = v0_q;
    a0_d      = a0_q;
    off_d     = off_q;
    nl_d      = nl_q;
    maddr_d   = maddr_q;
    cdata_d   = cdata_q;
    err_d     = 1'b0;
    gen_start = 1'b0;
    dig_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (syscall_req_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (pipe_empty_i) begin
          state_d = ST_DISPATCH;
          v0_d    = v0_i;
          a0_d    = a0_i;
          err_d   = !(v0_i inside {SVC_PRINT_INT, SVC_PRINT_STR, SVC_EXIT, SVC_PRINT_CHAR});
        end
      end
      ST_DISPATCH: begin
        case (v0_q)
          SVC_PRINT_INT: state_d = ST_INT_SIGN;
          SVC_PRINT_STR: begin
            off_d   = '0;
            maddr_d = a0_q;
            state_d = (MAX_STR_LEN == 0) ? ST_DONE : ST_STR_FETCH;
          end
          SVC_EXIT: state_d = ST_HALT;
          SVC_PRINT_CHAR: begin
            cdata_d = a0_q[BYTE_W-1:0];
            ret_d   = ST_DONE;
            state_d = ST_EMIT;
          end
          default: state_d = ST_DONE;
        endcase
      end
      ST_INT_SIGN: begin
        gen_start = 1'b1;
        nl_d      = 1'b0;
        if (a0_q[XLEN-1]) begin
          cdata_d = ASCII_MINUS;
          ret_d   = ST_INT_DIGIT;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_INT_DIGIT;
        end
      end
      ST_INT_DIGIT: begin
        // nl_q marks that the last digit has gone out and only '\n' remains.
        if (nl_q) begin
          nl_d    = 1'b0;
          cdata_d = ASCII_NL;
          ret_d   = ST_DONE;
          state_d = ST_EMIT;
        end else if (dig_valid) begin
          dig_ready = 1'b1;
          nl_d      = dig_last;
          cdata_d   = ASCII_ZERO + BYTE_W'(dig_val);
          ret_d     = ST_INT_DIGIT;
          state_d   = ST_EMIT;
        end
      end
      ST_STR_FETCH: begin
        if (bus.mem_ack) begin
          if (bus.mem_rdata == ASCII_NUL) begin
            state_d = ST_DONE;
          end else begin
            cdata_d = bus.mem_rdata;
            off_d   = off_q + XLEN'(1);
            ret_d   = ST_STR_FETCH;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (bus.con_ready) begin
          if (ret_q == ST_STR_FETCH && off_q == XLEN'(MAX_STR_LEN)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ret_q;
            maddr_d = a0_q + off_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered decodes of the next state.
  assign done_d   = (state_d == ST_DONE);
  assign halt_d   = (state_d == ST_HALT);
  assign mreq_d   = (state_d == ST_STR_FETCH);
  assign cvalid_d = (state_d == ST_EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      v0_q     <= '0;
      a0_q     <= '0;
      off_q    <= '0;
      nl_q     <= 1'b0;
      maddr_q  <= '0;
      cdata_q  <= '0;
      done_q   <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      mreq_q   <= 1'b0;
      cvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      v0_q     <= v0_d;
      a0_q     <= a0_d;
      off_q    <= off_d;
      nl_q     <= nl_d;
      maddr_q  <= maddr_d;
      cdata_q  <= cdata_d;
      done_q   <= done_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      mreq_q   <= mreq_d;
      cvalid_q <= cvalid_d;
    end
  end

  // Stall is combinational so the freeze lands in the detection cycle.
  assign stall_c_o = (state_q == ST_IDLE && syscall_req_i) ||
                     (state_q != ST_IDLE && state_q != ST_DONE);

  assign syscall_done_o = done_q;
  assign halt_o         = halt_q;
  assign svc_err_o      = err_q;
  assign bus.mem_req    = mreq_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.con_valid  = cvalid_q;
  assign bus.con_data   = cdata_q;

`ifdef SYSCALL_STATS_EN
  logic [XLEN-1:0] stat_sys_q, stat_chr_q;

  // Free-running counters, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sys_q <= '0;
      stat_chr_q <= '0;
    end else begin
      if (state_q == ST_DISPATCH)     stat_sys_q <= stat_sys_q + XLEN'(1);
      if (cvalid_q && bus.con_ready)  stat_chr_q <= stat_chr_q + XLEN'(1);
    end
  end

  assign stat_syscalls_o = stat_sys_q;
  assign stat_chars_o    = stat_chr_q;
`else
  assign stat_syscalls_o = '0;
  assign stat_chars_o    = '0;
`endif

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed bench for syscall_sequencer: drives syscalls, models the byte
// memory and console, and compares captured bytes/flags with hand-computed
// expectations.
module tb_syscall_sequencer;
  import syscall_pkg::*;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_req, pipe_empty;
  logic [31:0] v0, a0;
  logic        stall, done, halt, err;
  logic [31:0] st_sys, st_chr;

  syscall_sequencer_if bus();

  syscall_sequencer #(.MAX_STR_LEN(256)) dut (
    .clk             (clk),
    .rst             (rst),
    .syscall_req_i   (syscall_req),
    .pipe_empty_i    (pipe_empty),
    .v0_i            (v0),
    .a0_i            (a0),
    .stall_c_o       (stall),
    .syscall_done_o  (done),
    .halt_o          (halt),
    .svc_err_o       (err),
    .stat_syscalls_o (st_sys),
    .stat_chars_o    (st_chr),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  assign bus.mem_ack   = bus.mem_req;
  assign bus.mem_rdata = mem[bus.mem_addr[8:0]];

  int n_checks = 0, n_fail = 0;
  int stall_bad = 0, drain_bad = 0, pulse_bad = 0, stab_bad = 0, overlap_bad = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = -1;
  int exp_sys = 0, exp_chr = 0;
  bit ready_toggle = 1'b0;
  logic hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic [7:0]  con_q [$];
  logic [31:0] addr_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input byte_q_t exp);
    check_eq($sformatf("%s_len", tag), 32'(con_q.size()), 32'(exp.size()));
    foreach (exp[i])
      if (i < con_q.size())
        check_eq($sformatf("%s_b%0d", tag, i), 32'(con_q[i]), 32'(exp[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, 32'(stall), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_halt"}, 32'(halt), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_mem_req"}, 32'(bus.mem_req), 0);
    check_eq({tag, "_con_valid"}, 32'(bus.con_valid), 0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({tag, "_con_data"}, 32'(bus.con_data), 0);
    check_eq({tag, "_stat_sys"}, st_sys, 0);
    check_eq({tag, "_stat_chr"}, st_chr, 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef SYSCALL_STATS_EN
    check_eq({tag, "_stat_sys"}, st_sys, 32'(exp_sys));
    check_eq({tag, "_stat_chr"}, st_chr, 32'(exp_chr));
`else
    check_eq({tag, "_stat_sys"}, st_sys, 0);
    check_eq({tag, "_stat_chr"}, st_chr, 0);
`endif
  endtask

  // Console/memory monitor: ready is updated first, then the handshake that
  // the next rising edge will see is recorded.
  always @(negedge clk) begin
    bus.con_ready = (ready_toggle && bus.con_ready === 1'b1) ? 1'b0 : 1'b1;
    #2;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.con_valid && bus.con_ready) con_q.push_back(bus.con_data);
      if (bus.mem_req && bus.mem_ack) addr_q.push_back(bus.mem_addr);
      if (bus.mem_req && bus.con_valid) overlap_bad++;
      if (hold_pend && (!bus.con_valid || bus.con_data !== hold_data)) stab_bad++;
      hold_pend = bus.con_valid && !bus.con_ready;
      hold_data = bus.con_data;
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  // One syscall: v0/a0 hold the *_pre values until the pipe_empty cycle.
  task automatic run_svc(input logic [31:0] v0_pre, a0_pre, v0_real, a0_real,
                         input int drain, output int lat);
    int k;
    bit fin;
    k = 0; fin = 1'b0; lat = -1; err_cyc = -1;
    @(negedge clk);
    syscall_req = 1'b1; pipe_empty = 1'b0; v0 = v0_pre; a0 = a0_pre;
    #1;
    if (!stall) stall_bad++;
    while (!fin && k < 2000) begin
      @(negedge clk);
      k++;
      syscall_req = 1'b0;
      if (k < 1 + drain) begin
        pipe_empty = 1'b0; v0 = v0_pre; a0 = a0_pre;
      end else if (k == 1 + drain) begin
        pipe_empty = 1'b1; v0 = v0_real; a0 = a0_real;
      end else begin
        v0 = '0; a0 = '0;
      end
      #1;
      if (k <= drain && (bus.con_valid || bus.mem_req)) drain_bad++;
      if (err) err_cyc = k;
      if (done) begin
        fin = 1'b1;
        lat = k;
        if (stall) stall_bad++;
      end else if (!stall) begin
        stall_bad++;
      end
    end
    check_eq("svc_completes", 32'(fin), 1);
    @(negedge clk);
    #1;
    if (done || stall) pulse_bad++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t exp_q;
    byte_q_t empty_q;
    int lat, d0, e0;
    bit seen;

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h100] = 8'h48;
    mem[9'h101] = 8'h69;
    mem[9'h102] = 8'h00;
    rst = 1'b1; syscall_req = 1'b0; pipe_empty = 1'b1; v0 = '0; a0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // -1234
    con_q.delete(); d0 = done_cnt;
    run_svc(32'd1, 32'hFFFF_FB2E, 32'd1, 32'hFFFF_FB2E, 0, lat);
    exp_q = '{8'h2D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
    check_bytes("int_neg1234", exp_q);
    check_eq("int_neg1234_done", 32'(done_cnt - d0), 1);
    exp_sys += 1; exp_chr += 6;

    // zero
    con_q.delete();
    run_svc(32'd1, 32'd0, 32'd1, 32'd0, 0, lat);
    exp_q = '{8'h30, 8'h0A};
    check_bytes("int_zero", exp_q);
    exp_sys += 1; exp_chr += 2;

    // most negative
    con_q.delete();
    run_svc(32'd1, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, lat);
    exp_q = '{8'h2D, 8'h32, 8'h31, 8'h34, 8'h37, 8'h34, 8'h38, 8'h33, 8'h36, 8'h34, 8'h38, 8'h0A};
    check_bytes("int_min", exp_q);
    exp_sys += 1; exp_chr += 12;

    // interior zeros must not be suppressed
    con_q.delete();
    run_svc(32'd1, 32'd1000005, 32'd1, 32'd1000005, 0, lat);
    exp_q = '{8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0A};
    check_bytes("int_1000005", exp_q);
    exp_sys += 1; exp_chr += 8;

    // string "Hi" with a slow console
    con_q.delete(); addr_q.delete(); ready_toggle = 1'b1;
    run_svc(32'd4, 32'h100, 32'd4, 32'h100, 0, lat);
    ready_toggle = 1'b0;
    exp_q = '{8'h48, 8'h69};
    check_bytes("str_hi", exp_q);
    check_eq("str_reads", 32'(addr_q.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < addr_q.size()) check_eq($sformatf("str_addr%0d", i), addr_q[i], 32'h100 + 32'(i));
    check_eq("str_data_stable", 32'(stab_bad), 0);
    exp_sys += 1; exp_chr += 2;

    // char print, minimum latency
    con_q.delete();
    run_svc(32'd11, 32'h41, 32'd11, 32'h41, 0, lat);
    exp_q = '{8'h41};
    check_bytes("chr_a", exp_q);
    check_eq("chr_latency", 32'(lat), 4);
    exp_sys += 1; exp_chr += 1;

    // drain: operands latched only in the pipe_empty cycle
    con_q.delete();
    run_svc(32'd1, 32'h99, 32'd11, 32'h41, 5, lat);
    exp_q = '{8'h41};
    check_bytes("drain_chr", exp_q);
    check_eq("drain_latency", 32'(lat), 9);
    check_eq("drain_quiet", 32'(drain_bad), 0);
    exp_sys += 1; exp_chr += 1;

    // unknown service
    con_q.delete(); d0 = done_cnt; e0 = err_cnt;
    run_svc(32'd7, 32'd0, 32'd7, 32'd0, 0, lat);
    check_bytes("unk_svc", empty_q);
    check_eq("unk_err_pulses", 32'(err_cnt - e0), 1);
    check_eq("unk_err_cycle", 32'(err_cyc), 2);
    check_eq("unk_done", 32'(done_cnt - d0), 1);
    check_eq("unk_latency", 32'(lat), 3);
    exp_sys += 1;
    check_stats("stats_mid");

    // reset while the third digit of 1234 is being generated
    con_q.delete(); d0 = done_cnt; seen = 1'b0;
    @(negedge clk);
    syscall_req = 1'b1; pipe_empty = 1'b1; v0 = 32'd1; a0 = 32'd1234;
    @(negedge clk);
    syscall_req = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (con_q.size() >= 2) seen = 1'b1;
    end
    check_eq("rst_mid_reached", 32'(seen), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v0 = '0; a0 = '0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check_eq("rst_mid_bytes", 32'(con_q.size()), 2);
    check_eq("rst_mid_no_done", 32'(done_cnt - d0), 0);
    exp_sys = 0; exp_chr = 0;

    con_q.delete();
    run_svc(32'd11, 32'h5A, 32'd11, 32'h5A, 0, lat);
    exp_q = '{8'h5A};
    check_bytes("post_rst_chr", exp_q);
    exp_sys += 1; exp_chr += 1;
    check_stats("stats_post_rst");

    // exit: sticky halt, later syscalls ignored
    con_q.delete(); d0 = done_cnt;
    @(negedge clk);
    syscall_req = 1'b1; pipe_empty = 1'b1; v0 = 32'd10; a0 = '0;
    @(negedge clk);
    syscall_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("exit_halt", 32'(halt), 1);
    check_eq("exit_stall", 32'(stall), 1);
    @(negedge clk);
    syscall_req = 1'b1; v0 = 32'd11; a0 = 32'h41;
    @(negedge clk);
    syscall_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_eq("halt_sticky", 32'(halt), 1);
    check_eq("halt_stall", 32'(stall), 1);
    check_eq("halt_no_bytes", 32'(con_q.size()), 0);
    check_eq("halt_no_done", 32'(done_cnt - d0), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v0 = '0; a0 = '0;
    #1;
    check_reset_outputs("halt_rst");

    check_eq("stall_window", 32'(stall_bad), 0);
    check_eq("done_single_pulse", 32'(pulse_bad), 0);
    check_eq("mem_con_exclusive", 32'(overlap_bad), 0);
    check_eq("con_data_stable", 32'(stab_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
